// File: rtl/spi_master_multi_if.sv
// Control-side bus of spi_master_multi: request, configuration and receive handshake.
interface spi_master_multi_if #(
    parameter int DATA_W = 20,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8,
    parameter int GAP_W  = 6
);
    // One spare select bit so an out-of-range slave index can be presented and refused.
    localparam int SS_W = $clog2(NUM_SS) + 1;

    // Handshake: a cycle with we=1 is a request and is answered the next cycle by exactly
    // one of accept/reject; rd=1 is answered the next cycle by read_end, and done pulses
    // once per completed frame with rx_data/rx_valid already updated in that cycle.
    logic              we;
    logic [DATA_W-1:0] data_in;
    logic [SS_W-1:0]   ss_sel;
    logic [DIV_W-1:0]  clk_div;
    logic              cpol;
    logic              cpha;
    logic [GAP_W-1:0]  gap_cycles;
    logic              rd;
    logic              accept;
    logic              reject;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              read_end;
    logic              overrun;

    modport master (
        output we, data_in, ss_sel, clk_div, cpol, cpha, gap_cycles, rd,
        input  accept, reject, busy, done, rx_data, rx_valid, read_end, overrun
    );

    modport slave (
        input  we, data_in, ss_sel, clk_div, cpol, cpha, gap_cycles, rd,
        output accept, reject, busy, done, rx_data, rx_valid, read_end, overrun
    );
endinterface

// File: rtl/spi_master_multi.sv
// Multi-slave SPI master: one DATA_W-bit full-duplex frame per request, all four SPI modes.
// Define SPI_MASTER_MULTI_LOOPBACK_EN to feed the receive shifter from mosi instead of miso.
module spi_master_multi #(
    parameter int DATA_W = 20,
    parameter int NUM_SS = 4,
    parameter int DIV_W  = 8,
    parameter int GAP_W  = 6
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    spi_master_multi_if.slave   bus,
    output logic                sclk_o,
    output logic                mosi_o,
    input  logic                miso_i,
    output logic [NUM_SS-1:0]   ss_n_o,
    output logic [2:0]          state_o
);
    localparam int SS_W  = $clog2(NUM_SS) + 1;
    localparam int EW    = $clog2(2 * DATA_W + 1);
    localparam logic [SS_W-1:0] SS_LIMIT  = SS_W'(NUM_SS);
    localparam logic [EW-1:0]   LAST_EDGE = EW'(2 * DATA_W);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    cnt_q, cnt_d, div_q, div_d;
    logic [EW-1:0]       edge_q, edge_d, edge_k;
    logic [GAP_W-1:0]    gcnt_q, gcnt_d, gap_q, gap_d;
    logic [DATA_W-1:0]   tx_q, tx_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
    logic                cpol_q, cpol_d, cpha_q, cpha_d, sclk_q, sclk_d;
    logic [NUM_SS-1:0]   ss_n_q, ss_n_d;
    logic                accept_q, accept_d, reject_q, reject_d, done_q, done_d;
    logic                read_end_q, read_end_d, rx_valid_q, rx_valid_d, overrun_q, overrun_d;
    logic                rx_bit, lead;

`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
    assign rx_bit = tx_q[DATA_W-1] | (miso_i & 1'b0);
`else
    assign rx_bit = miso_i;
`endif

    assign edge_k = edge_q + EW'(1);
    // Odd edges move sclk away from cpol (leading), even edges return it (trailing).
    assign lead   = edge_k[0];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        edge_d     = edge_q;
        gcnt_d     = gcnt_q;
        gap_d      = gap_q;
        tx_d       = tx_q;
        rx_sh_d    = rx_sh_q;
        rx_data_d  = rx_data_q;
        cpol_d     = cpol_q;
        cpha_d     = cpha_q;
        sclk_d     = sclk_q;
        ss_n_d     = ss_n_q;
        accept_d   = 1'b0;
        reject_d   = bus.we && (state_q != S_IDLE);
        done_d     = 1'b0;
        read_end_d = bus.rd;
        rx_valid_d = bus.rd ? 1'b0 : rx_valid_q;
        overrun_d  = overrun_q;

        case (state_q)
            S_IDLE: begin
                if (bus.we) begin
                    if (bus.ss_sel < SS_LIMIT) begin
                        accept_d = 1'b1;
                        tx_d     = bus.data_in;
                        div_d    = bus.clk_div;
                        cpol_d   = bus.cpol;
                        cpha_d   = bus.cpha;
                        gap_d    = bus.gap_cycles;
                        sclk_d   = bus.cpol;
                        cnt_d    = '0;
                        edge_d   = '0;
                        for (int i = 0; i < NUM_SS; i++) begin
                            ss_n_d[i] = (bus.ss_sel != SS_W'(i));
                        end
                        state_d  = S_SETUP;
                    end else begin
                        reject_d = 1'b1;
                    end
                end
            end
            S_SETUP, S_SHIFT: begin
                if (cnt_q == div_q) begin
                    cnt_d  = '0;
                    edge_d = edge_k;
                    sclk_d = ~sclk_q;
                    if (lead != cpha_q) begin
                        rx_sh_d = {rx_sh_q[DATA_W-2:0], rx_bit};
                    // cpha=1 keeps the MSB on the first leading edge; cpha=0 keeps mosi after the last edge.
                    end else if (lead ? (edge_q != '0) : (edge_k != LAST_EDGE)) begin
                        tx_d = {tx_q[DATA_W-2:0], 1'b0};
                    end
                    state_d = (edge_k == LAST_EDGE) ? S_HOLD : S_SHIFT;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == div_q) begin
                    ss_n_d     = '1;
                    rx_data_d  = rx_sh_q;
                    done_d     = 1'b1;
                    rx_valid_d = 1'b1;
                    if (rx_valid_q && !bus.rd) overrun_d = 1'b1;
                    gcnt_d     = '0;
                    state_d    = (gap_q == '0) ? S_IDLE : S_GAP;
                end else begin
                    cnt_d = cnt_q + DIV_W'(1);
                end
            end
            S_GAP: begin
                if (gcnt_q == gap_q - GAP_W'(1)) state_d = S_IDLE;
                else gcnt_d = gcnt_q + GAP_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            div_q      <= '0;
            edge_q     <= '0;
            gcnt_q     <= '0;
            gap_q      <= '0;
            tx_q       <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            sclk_q     <= 1'b0;
            ss_n_q     <= '1;
            accept_q   <= 1'b0;
            reject_q   <= 1'b0;
            done_q     <= 1'b0;
            read_end_q <= 1'b0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            edge_q     <= edge_d;
            gcnt_q     <= gcnt_d;
            gap_q      <= gap_d;
            tx_q       <= tx_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            sclk_q     <= sclk_d;
            ss_n_q     <= ss_n_d;
            accept_q   <= accept_d;
            reject_q   <= reject_d;
            done_q     <= done_d;
            read_end_q <= read_end_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
        end
    end

    assign bus.accept   = accept_q;
    assign bus.reject   = reject_q;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.done     = done_q;
    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
    assign bus.read_end = read_end_q;
    assign bus.overrun  = overrun_q;
    assign sclk_o       = sclk_q;
    assign mosi_o       = tx_q[DATA_W-1];
    assign ss_n_o       = ss_n_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_spi_master_multi.sv
// Self-checking bench for spi_master_multi with a mode-aware SPI slave model and rx scoreboard.
module tb_spi_master_multi;
    localparam int DW    = 20;
    localparam int NSS   = 4;
    localparam int DIV_W = 8;
    localparam int GAP_W = 6;
    localparam int SS_W  = $clog2(NSS) + 1;
`ifdef SPI_MASTER_MULTI_LOOPBACK_EN
    localparam bit LOOPBACK = 1'b1;
`else
    localparam bit LOOPBACK = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           sclk, mosi;
    logic           miso = 1'b0;
    logic [NSS-1:0] ss_n;
    logic [2:0]     state;

    spi_master_multi_if #(.DATA_W(DW), .NUM_SS(NSS), .DIV_W(DIV_W), .GAP_W(GAP_W)) bus_if();

    spi_master_multi #(.DATA_W(DW), .NUM_SS(NSS), .DIV_W(DIV_W), .GAP_W(GAP_W)) dut (
        .clk_i(clk), .rst_ni(rst_n), .bus(bus_if), .sclk_o(sclk), .mosi_o(mosi),
        .miso_i(miso), .ss_n_o(ss_n), .state_o(state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_cnt = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] tx_exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Slave model, evaluated at negedge: drives miso on its shift edge, samples mosi on its sample edge.
    logic          s_cpol = 1'b0, s_cpha = 1'b0, s_prev_act = 1'b0, s_prev_sclk = 1'b0, s_first = 1'b0;
    logic [DW-1:0] s_pat = '0, s_rx = '0;
    int            s_idx = 0, s_edges = 0;
    always @(negedge clk) begin : slave
        logic act;
        act = (ss_n != '1);
        if (act && !s_prev_act) begin
            s_rx = '0; s_edges = 0; s_idx = DW - 1;
            if (!s_cpha) begin miso = s_pat[DW-1]; s_idx = DW - 2; end
        end else if (act && sclk != s_prev_sclk) begin
            s_edges++;
            if (s_edges == 1) s_first = sclk;
            if ((sclk != s_cpol) == !s_cpha) s_rx = {s_rx[DW-2:0], mosi};
            else if (s_idx >= 0) begin miso = s_pat[s_idx]; s_idx--; end
        end
        s_prev_act = act; s_prev_sclk = sclk;
    end

    always @(negedge clk) begin : monitor
        logic [DW-1:0] e_rx, e_tx;
        if (rst_n && bus_if.done) begin
            done_cnt++;
            if (exp_q.size() == 0) check("unexpected_done", 32'd1, 32'd0);
            else begin
                e_rx = exp_q.pop_front();
                e_tx = tx_exp_q.pop_front();
                check("rx_data", bus_if.rx_data, e_rx);
                check("slave_mosi_word", s_rx, e_tx);
                check("slave_edges", s_edges, 2 * DW);
                check("ss_n_release", ss_n, 4'hF);
                check("rx_valid_set", bus_if.rx_valid, 1);
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic [SS_W-1:0] sel, input logic [DIV_W-1:0] div,
                        input logic pol, input logic pha, input logic [GAP_W-1:0] gap,
                        input logic [DW-1:0] pat, output int acc_cyc);
        logic [NSS-1:0] exp_ss;
        exp_ss = '1;
        exp_ss[sel[1:0]] = 1'b0;
        bus_if.we = 1'b1; bus_if.data_in = d; bus_if.ss_sel = sel; bus_if.clk_div = div;
        bus_if.cpol = pol; bus_if.cpha = pha; bus_if.gap_cycles = gap;
        s_cpol = pol; s_cpha = pha; s_pat = pat;
        exp_q.push_back(LOOPBACK ? d : pat);
        tx_exp_q.push_back(d);
        @(negedge clk);
        bus_if.we = 1'b0;
        check("accept", bus_if.accept, 1);
        check("busy_on_accept", bus_if.busy, 1);
        check("ss_n_select", ss_n, exp_ss);
        check("sclk_idle_cpol", sclk, pol);
        check("mosi_msb", mosi, d[DW-1]);
        acc_cyc = cyc;
    endtask

    task automatic wait_done(input int budget, output int at);
        int n;
        n = 0;
        while (!bus_if.done && n < budget) begin @(negedge clk); n++; end
        check("done_within_budget", bus_if.done, 1);
        at = cyc;
    endtask

    task automatic wait_idle(input int budget, output int n);
        n = 0;
        while (bus_if.busy && n < budget) begin @(negedge clk); n++; end
    endtask

    task automatic do_read();
        bus_if.rd = 1'b1;
        @(negedge clk);
        bus_if.rd = 1'b0;
        check("read_end", bus_if.read_end, 1);
        check("rx_valid_clear", bus_if.rx_valid, 0);
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, dn, n, d0;
        logic [DW-1:0] d, p;
        logic [DIV_W-1:0] dv;
        logic [GAP_W-1:0] g;
        logic pol, pha;

        bus_if.we = 0; bus_if.data_in = '0; bus_if.ss_sel = '0; bus_if.clk_div = '0;
        bus_if.cpol = 0; bus_if.cpha = 0; bus_if.gap_cycles = '0; bus_if.rd = 0;
        repeat (3) @(negedge clk);
        check("rst_accept", bus_if.accept, 0);
        check("rst_reject", bus_if.reject, 0);
        check("rst_busy", bus_if.busy, 0);
        check("rst_done", bus_if.done, 0);
        check("rst_read_end", bus_if.read_end, 0);
        check("rst_rx_valid", bus_if.rx_valid, 0);
        check("rst_overrun", bus_if.overrun, 0);
        check("rst_rx_data", bus_if.rx_data, 0);
        check("rst_sclk", sclk, 0);
        check("rst_mosi", mosi, 0);
        check("rst_ss_n", ss_n, 4'hF);
        rst_n = 1'b1;
        @(negedge clk);

        // Mode 0, clk_div=4, slave 2, word 5.
        send(20'd5, 3'd2, 8'd4, 1'b0, 1'b0, 6'd0, 20'd5, acc);
        check("ss_n_1011", ss_n, 4'b1011);
        wait_done(400, dn);
        check("latency_div4", dn - acc, 205);
        check("busy_after_done_nogap", bus_if.busy, 0);
        check("sclk_idle_mode0", sclk, 0);
        do_read();

        // A request during a frame is refused and does not start a second frame.
        send(20'd40, 3'd0, 8'd4, 1'b0, 1'b0, 6'd0, 20'd40, acc);
        repeat (30) @(negedge clk);
        bus_if.we = 1'b1; bus_if.data_in = 20'hFD555; bus_if.ss_sel = 3'd1;
        @(negedge clk);
        bus_if.we = 1'b0;
        check("busy_reject", bus_if.reject, 1);
        check("busy_no_accept", bus_if.accept, 0);
        check("busy_ss_n_kept", ss_n, 4'b1110);
        d0 = done_cnt;
        wait_done(400, dn);
        repeat (30) @(negedge clk);
        check("single_frame", done_cnt - d0, 1);
        check("no_second_frame_busy", bus_if.busy, 0);
        check("no_second_frame_ss", ss_n, 4'hF);
        do_read();

        // Out-of-range slave index.
        bus_if.we = 1'b1; bus_if.ss_sel = 3'd5; bus_if.data_in = 20'h12345;
        @(negedge clk);
        bus_if.we = 1'b0;
        check("badsel_reject", bus_if.reject, 1);
        check("badsel_no_accept", bus_if.accept, 0);
        check("badsel_ss_n", ss_n, 4'hF);
        check("badsel_busy", bus_if.busy, 0);
        @(negedge clk);
        check("reject_is_pulse", bus_if.reject, 0);

        // Mode 3 against the slave returning A5A5A.
        d = 20'($urandom_range(0, (1 << DW) - 1));
        send(d, 3'd1, 8'd2, 1'b1, 1'b1, 6'd0, 20'hA5A5A, acc);
        wait_done(400, dn);
        check("latency_mode3", dn - acc, (2 * DW + 1) * 3);
        check("mode3_first_edge_falling", s_first, 0);
        check("mode3_sclk_idle", sclk, 1);
        repeat (3) @(negedge clk);
        check("mode3_sclk_idle_later", sclk, 1);

        // rd in the done cycle: done wins, no overrun although rx_valid was still set.
        d = 20'($urandom_range(0, (1 << DW) - 1));
        p = 20'($urandom_range(0, (1 << DW) - 1));
        send(d, 3'd3, 8'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'd0, p, acc);
        repeat (2 * DW) @(negedge clk);
        bus_if.rd = 1'b1;
        @(negedge clk);
        bus_if.rd = 1'b0;
        check("rd_done_done", bus_if.done, 1);
        check("rd_done_read_end", bus_if.read_end, 1);
        check("rd_done_rx_valid", bus_if.rx_valid, 1);
        check("rd_done_no_overrun", bus_if.overrun, 0);
        do_read();

        // Two frames without rd, with an inter-frame gap.
        send(20'd35, 3'd3, 8'd1, 1'b0, 1'b1, 6'd3, 20'd35, acc);
        wait_done(400, dn);
        check("first_no_overrun", bus_if.overrun, 0);
        check("busy_in_gap", bus_if.busy, 1);
        wait_idle(20, n);
        check("gap_length", n, 3);
        send(20'd50, 3'd0, 8'd1, 1'b1, 1'b0, 6'd3, 20'd50, acc);
        wait_done(400, dn);
        check("overrun_set", bus_if.overrun, 1);
        wait_idle(20, n);
        do_read();
        check("overrun_sticky", bus_if.overrun, 1);

        // Random frames.
        for (int i = 0; i < 3; i++) begin
            d   = 20'($urandom_range(0, (1 << DW) - 1));
            p   = 20'($urandom_range(0, (1 << DW) - 1));
            dv  = 8'($urandom_range(0, 3));
            g   = 6'($urandom_range(0, 4));
            pol = 1'($urandom_range(0, 1));
            pha = 1'($urandom_range(0, 1));
            send(d, 3'($urandom_range(0, NSS - 1)), dv, pol, pha, g, p, acc);
            wait_done(800, dn);
            check("latency_rand", dn - acc, (2 * DW + 1) * (int'(dv) + 1));
            wait_idle(20, n);
            check("gap_rand", n, int'(g));
            do_read();
        end

        // Reset in the middle of SHIFT aborts the frame.
        send(20'h3C3C3, 3'd3, 8'd3, 1'b0, 1'b0, 6'd2, 20'h0F0F0, acc);
        repeat (60) @(negedge clk);
        check("in_shift", state, 3'd2);
        d0 = done_cnt;
        #2 rst_n = 1'b0;
        #1;
        check("abort_ss_n", ss_n, 4'hF);
        check("abort_busy", bus_if.busy, 0);
        check("abort_sclk", sclk, 0);
        check("abort_overrun_clr", bus_if.overrun, 0);
        check("abort_rx_valid", bus_if.rx_valid, 0);
        exp_q.delete();
        tx_exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("abort_no_done", done_cnt - d0, 0);
        send(20'h9ABCD, 3'd1, 8'd1, 1'b0, 1'b0, 6'd0, 20'h13579, acc);
        wait_done(400, dn);
        check("latency_after_reset", dn - acc, (2 * DW + 1) * 2);
        do_read();

        repeat (5) @(negedge clk);
        check("scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
